psum_drain_acc: RTL and testbench

PSUM_DRAIN_ACC -- requirements
Module: psum_drain_acc

---
 rtl/psum_drain_acc.sv | 227 ++++++++++++++++++++++
 tb/tb_psum_drain_acc.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_drain_acc.sv
// ----------------------------------------------------------------------------
// psum_drain_acc
//
// Moves the PE array's partial sums into the psum global buffer, one
// GBF-sized slice per cycle. The slices go out MSB first. When accumulation
// is active, each slice is added lane-wise to the word already stored at the
// same address (read-modify-write) before it is written back.
//
// A drain takes SLICES+1 cycles, counted as d = 0..SLICES:
//   d = 0..SLICES-1 : register slice d and, if accumulating, issue a read of
//                     base+d
//   d = 1..SLICES   : write slice d-1 (plus the read data) to base+d-1
// The read data arrives one cycle after the read, so it lines up with the
// write of the same slice.
//
// Address walk: rel_cnt picks the base (rel_cnt*SLICES) inside the buffer.
// irrel_cnt counts completed passes over the buffer. w_num flips between the
// two buffers when irrel_cnt wraps. The first pass into a buffer never
// accumulates, because there is nothing valid to read back yet.
//
// Ports
//   clk, reset        : clock (rising edge) and asynchronous active-high reset
//   psum_out          : PE array psums, held stable while busy
//   start             : drain request
//   conv_finish       : layer end; leads to HALT once any drain in progress
//                       has finished
//   cfg_rel_num       : drains per irrelevant pass (0 is treated as 1)
//   cfg_irrel_num     : passes per buffer (0 is treated as 1)
//   cfg_acc_en        : enable read-modify-write accumulation
//   gbf_rd_data       : psum_gbf read data, valid 1 cycle after gbf_rd_en
//   psum_rf_addr      : PE psum RF entry currently being drained
//   gbf_rd_en/addr    : psum_gbf read port
//   out_data, w_en,
//   w_addr, w_num     : psum_gbf write port and buffer select
//   busy, done        : drain in progress / one-cycle end-of-drain pulse
//   halted            : layer finished, left only by reset
//   start_err         : sticky flag, set when start arrives while not idle
// ----------------------------------------------------------------------------
module psum_drain_acc #(
    parameter int ROW                   = 16,
    parameter int COL                   = 16,
    parameter int DATA_BITWIDTH         = 16,
    parameter int GBF_DATA_BITWIDTH     = 512,
    parameter int PSUM_RF_ADDR_BITWIDTH = 2,
    parameter int GBF_ADDR_BITWIDTH     = 5
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [DATA_BITWIDTH*ROW*COL-1:0]     psum_out,
    input  logic                                 start,
    input  logic                                 conv_finish,
    input  logic [7:0]                           cfg_rel_num,
    input  logic [7:0]                           cfg_irrel_num,
    input  logic                                 cfg_acc_en,
    input  logic [GBF_DATA_BITWIDTH-1:0]         gbf_rd_data,
    output logic [PSUM_RF_ADDR_BITWIDTH-1:0]     psum_rf_addr,
    output logic                                 gbf_rd_en,
    output logic [GBF_ADDR_BITWIDTH-1:0]         gbf_rd_addr,
    output logic [GBF_DATA_BITWIDTH-1:0]         out_data,
    output logic                                 w_en,
    output logic [GBF_ADDR_BITWIDTH-1:0]         w_addr,
    output logic                                 w_num,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 halted,
    output logic                                 start_err
);

    localparam int W      = DATA_BITWIDTH * ROW * COL;
    localparam int G      = GBF_DATA_BITWIDTH;
    localparam int SLICES = W / G;
    localparam int LANES  = G / DATA_BITWIDTH;
    localparam int CW     = $clog2(SLICES + 1);
    localparam int SIW    = (SLICES > 1) ? $clog2(SLICES) : 1;

    generate
        if ((W % G) != 0 || SLICES < 1 || (G % DATA_BITWIDTH) != 0 || LANES < 1) begin : g_param_check
            $error("psum_drain_acc: SLICES and LANES must be integers >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, DRAIN, HALT} state_t;

    state_t                           state_reg, state_next;
    logic [CW-1:0]                    d_cnt_reg;
    logic [7:0]                       rel_cnt_reg, irrel_cnt_reg;
    logic [7:0]                       rel_num_reg, irrel_num_reg;
    logic                             acc_active_reg;
    logic                             finish_seen_reg;
    logic [PSUM_RF_ADDR_BITWIDTH-1:0] psum_rf_addr_reg;
    logic                             w_num_reg;
    logic                             start_err_reg;
    logic [G-1:0]                     slice_reg;

    logic [G-1:0]                     slices [SLICES];
    logic [G-1:0]                     lane_sum;
    logic                             start_drain;
    logic                             last_cycle;
    logic                             write_phase;
    logic                             read_phase;
    logic [GBF_ADDR_BITWIDTH-1:0]     base_addr;
    logic [GBF_ADDR_BITWIDTH-1:0]     d_addr;

    // Slice gi is the gi-th GBF word counted from the MSB end of psum_out.
    genvar gi;
    generate
        for (gi = 0; gi < SLICES; gi++) begin : g_slice
            assign slices[gi] = psum_out[W-1-gi*G -: G];
        end
    endgenerate

    // Lane-wise add with no carry between lanes; each lane wraps on its own.
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [DATA_BITWIDTH-1:0] addend;
            assign addend = acc_active_reg ? gbf_rd_data[gi*DATA_BITWIDTH +: DATA_BITWIDTH]
                                           : '0;
            assign lane_sum[gi*DATA_BITWIDTH +: DATA_BITWIDTH] =
                slice_reg[gi*DATA_BITWIDTH +: DATA_BITWIDTH] + addend;
        end
    endgenerate

    // conv_finish has priority over start when both arrive in IDLE.
    assign start_drain = (state_reg == IDLE) && start && !conv_finish;
    assign last_cycle  = (state_reg == DRAIN) && (d_cnt_reg == CW'(SLICES));
    assign write_phase = (state_reg == DRAIN) && (d_cnt_reg != '0);
    assign read_phase  = (state_reg == DRAIN) && !last_cycle && acc_active_reg;
    assign base_addr   = GBF_ADDR_BITWIDTH'(32'(rel_cnt_reg) * SLICES);
    assign d_addr      = GBF_ADDR_BITWIDTH'(d_cnt_reg);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (conv_finish) begin
                    state_next = HALT;
                end else if (start) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // A conv_finish on the final cycle counts as seen during the drain.
                if (last_cycle) begin
                    state_next = (finish_seen_reg || conv_finish) ? HALT : IDLE;
                end
            end
            HALT:    state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_cnt_reg        <= '0;
            rel_cnt_reg      <= '0;
            irrel_cnt_reg    <= '0;
            rel_num_reg      <= 8'd1;
            irrel_num_reg    <= 8'd1;
            acc_active_reg   <= 1'b0;
            finish_seen_reg  <= 1'b0;
            psum_rf_addr_reg <= '0;
            w_num_reg        <= 1'b0;
            start_err_reg    <= 1'b0;
            slice_reg        <= '0;
        end else begin
            if (start_drain) begin
                rel_num_reg     <= (cfg_rel_num == 8'd0) ? 8'd1 : cfg_rel_num;
                irrel_num_reg   <= (cfg_irrel_num == 8'd0) ? 8'd1 : cfg_irrel_num;
                // No read-back on the first pass into a buffer.
                acc_active_reg  <= cfg_acc_en && (irrel_cnt_reg != 8'd0);
                d_cnt_reg       <= '0;
                finish_seen_reg <= 1'b0;
            end

            if (state_reg == DRAIN) begin
                if (conv_finish) begin
                    finish_seen_reg <= 1'b1;
                end
                if (!last_cycle) begin
                    slice_reg <= slices[d_cnt_reg[SIW-1:0]];
                    d_cnt_reg <= d_cnt_reg + CW'(1);
                end else begin
                    d_cnt_reg        <= '0;
                    psum_rf_addr_reg <= psum_rf_addr_reg + PSUM_RF_ADDR_BITWIDTH'(1);
                    if (rel_cnt_reg == rel_num_reg - 8'd1) begin
                        rel_cnt_reg <= '0;
                        if (irrel_cnt_reg == irrel_num_reg - 8'd1) begin
                            irrel_cnt_reg <= '0;
                            w_num_reg     <= ~w_num_reg;
                        end else begin
                            irrel_cnt_reg <= irrel_cnt_reg + 8'd1;
                        end
                    end else begin
                        rel_cnt_reg <= rel_cnt_reg + 8'd1;
                    end
                end
            end

            if ((state_reg == DRAIN || state_reg == HALT) && start) begin
                start_err_reg <= 1'b1;
            end
        end
    end

    // Outputs are decoded from registers only, so an asynchronous reset
    // drops every enable in the same instant it clears the state.
    assign busy         = (state_reg == DRAIN);
    assign done         = last_cycle;
    assign halted       = (state_reg == HALT);
    assign w_en         = write_phase;
    assign w_addr       = write_phase ? (base_addr + d_addr - GBF_ADDR_BITWIDTH'(1)) : '0;
    assign out_data     = write_phase ? lane_sum : '0;
    assign gbf_rd_en    = read_phase;
    assign gbf_rd_addr  = read_phase ? (base_addr + d_addr) : '0;
    assign psum_rf_addr = psum_rf_addr_reg;
    assign w_num        = w_num_reg;
    assign start_err    = start_err_reg;

endmodule

// File: tb/tb_psum_drain_acc.sv
// ----------------------------------------------------------------------------
// Directed testbench for psum_drain_acc with the default parameters
// (SLICES = 8, LANES = 32). Inputs change 1 time unit after the rising edge.
// Outputs are sampled on the falling edge, except the asynchronous reset
// check, which samples shortly after reset rises.
// ----------------------------------------------------------------------------
module tb_psum_drain_acc;

    localparam int D      = 16;
    localparam int ROW    = 16;
    localparam int COL    = 16;
    localparam int G      = 512;
    localparam int W      = D * ROW * COL;
    localparam int SLICES = W / G;
    localparam int LANES  = G / D;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  psum_out;
    logic          start;
    logic          conv_finish;
    logic [7:0]    cfg_rel_num;
    logic [7:0]    cfg_irrel_num;
    logic          cfg_acc_en;
    logic [G-1:0]  gbf_rd_data;
    logic [1:0]    psum_rf_addr;
    logic          gbf_rd_en;
    logic [4:0]    gbf_rd_addr;
    logic [G-1:0]  out_data;
    logic          w_en;
    logic [4:0]    w_addr;
    logic          w_num;
    logic          busy;
    logic          done;
    logic          halted;
    logic          start_err;

    int total = 0;
    int bad   = 0;

    psum_drain_acc dut (
        .clk           (clk),
        .reset         (reset),
        .psum_out      (psum_out),
        .start         (start),
        .conv_finish   (conv_finish),
        .cfg_rel_num   (cfg_rel_num),
        .cfg_irrel_num (cfg_irrel_num),
        .cfg_acc_en    (cfg_acc_en),
        .gbf_rd_data   (gbf_rd_data),
        .psum_rf_addr  (psum_rf_addr),
        .gbf_rd_en     (gbf_rd_en),
        .gbf_rd_addr   (gbf_rd_addr),
        .out_data      (out_data),
        .w_en          (w_en),
        .w_addr        (w_addr),
        .w_num         (w_num),
        .busy          (busy),
        .done          (done),
        .halted        (halted),
        .start_err     (start_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        reset       = 1'b1;
        start       = 1'b0;
        conv_finish = 1'b0;
        tick;
        tick;
        reset = 1'b0;
    endtask

    // Expected content of slice k, with slice 0 taken from the MSB end.
    function automatic logic [G-1:0] pattern_slice(input int k);
        logic [D-1:0] lane;
        lane = 16'hA000 + 16'(k);
        return {LANES{lane}};
    endfunction

    task automatic load_pattern;
        for (int k = 0; k < SLICES; k++) begin
            psum_out[W-1-k*G -: G] = pattern_slice(k);
        end
    endtask

    task automatic test_reset;
        logic [6:0] got_flags;
        @(negedge clk);
        got_flags = {busy, done, halted, w_en, gbf_rd_en, w_num, start_err};
        total++;
        if (got_flags !== 7'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=%b", got_flags, 7'b0);
        end
        total++;
        if ({psum_rf_addr, w_addr, gbf_rd_addr} !== 12'b0 || out_data !== '0) begin
            bad++;
            $display("FAIL reset_values rf=%0d wa=%0d ra=%0d od_nonzero=%b exp all 0",
                     psum_rf_addr, w_addr, gbf_rd_addr, (out_data != '0));
        end
        tick;
        reset = 1'b0;
        tick;
        @(negedge clk);
        total++;
        if ({busy, w_en, halted} !== 3'b000) begin
            bad++;
            $display("FAIL reset_idle got=%b exp=000", {busy, w_en, halted});
        end
        $display("test_reset done");
    endtask

    task automatic test_single_drain;
        logic [3:0] exp_ctl;
        apply_reset;
        cfg_rel_num = 8'd2; cfg_irrel_num = 8'd1; cfg_acc_en = 1'b0;
        load_pattern;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int d = 0; d <= SLICES; d++) begin
            @(negedge clk);
            exp_ctl = {1'b1, (d != 0), (d == SLICES), 1'b0};
            total++;
            if ({busy, w_en, done, gbf_rd_en} !== exp_ctl) begin
                bad++;
                $display("FAIL single_ctl d=%0d got=%b exp=%b", d, {busy, w_en, done, gbf_rd_en}, exp_ctl);
            end
            if (d > 0) begin
                total++;
                if (w_addr !== 5'(d - 1)) begin
                    bad++;
                    $display("FAIL single_waddr d=%0d got=%0d exp=%0d", d, w_addr, d - 1);
                end
                total++;
                if (out_data !== pattern_slice(d - 1)) begin
                    bad++;
                    $display("FAIL single_data d=%0d got=%h exp=%h", d, out_data, pattern_slice(d - 1));
                end
            end else begin
                total++;
                if (out_data !== '0) begin
                    bad++;
                    $display("FAIL single_data_idle d=0 got=%h exp=0", out_data);
                end
            end
            tick;
        end
        @(negedge clk);
        total++;
        if ({busy, w_en, psum_rf_addr, w_num} !== {1'b0, 1'b0, 2'd1, 1'b0}) begin
            bad++;
            $display("FAIL single_end got busy=%b wen=%b rf=%0d wnum=%b exp 0 0 1 0",
                     busy, w_en, psum_rf_addr, w_num);
        end
        $display("test_single_drain done");
    endtask

    task automatic test_back_to_back;
        int   exp_base;
        logic exp_wnum;
        apply_reset;
        cfg_rel_num = 8'd2; cfg_irrel_num = 8'd1; cfg_acc_en = 1'b0;
        load_pattern;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int n = 0; n < 3; n++) begin
            exp_base = (n == 1) ? 8 : 0;
            for (int d = 0; d <= SLICES; d++) begin
                @(negedge clk);
                if (d > 0) begin
                    total++;
                    if ({w_en, done, w_addr} !== {1'b1, (d == SLICES), 5'(exp_base + d - 1)}) begin
                        bad++;
                        $display("FAIL b2b_write n=%0d d=%0d got wen=%b done=%b wa=%0d exp 1 %b %0d",
                                 n, d, w_en, done, w_addr, (d == SLICES), exp_base + d - 1);
                    end
                end
                tick;
            end
            if (n < 2) start = 1'b1;
            @(negedge clk);
            exp_wnum = (n != 0);
            total++;
            if ({w_num, psum_rf_addr} !== {exp_wnum, 2'(n + 1)}) begin
                bad++;
                $display("FAIL b2b_state n=%0d got wnum=%b rf=%0d exp %b %0d",
                         n, w_num, psum_rf_addr, exp_wnum, n + 1);
            end
            if (n < 2) begin
                tick;
                start = 1'b0;
            end
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_accumulate;
        logic         exp_rd;
        logic [G-1:0] exp_out;
        apply_reset;
        cfg_rel_num = 8'd1; cfg_irrel_num = 8'd2; cfg_acc_en = 1'b1;
        psum_out    = {(ROW*COL){16'h0001}};
        gbf_rd_data = {LANES{16'hFFFF}};
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int n = 0; n < 2; n++) begin
            exp_out = (n == 0) ? {LANES{16'h0001}} : {G{1'b0}};
            for (int d = 0; d <= SLICES; d++) begin
                @(negedge clk);
                exp_rd = (n == 1) && (d < SLICES);
                total++;
                if (gbf_rd_en !== exp_rd) begin
                    bad++;
                    $display("FAIL acc_rden n=%0d d=%0d got=%b exp=%b", n, d, gbf_rd_en, exp_rd);
                end
                if (exp_rd) begin
                    total++;
                    if (gbf_rd_addr !== 5'(d)) begin
                        bad++;
                        $display("FAIL acc_raddr n=%0d d=%0d got=%0d exp=%0d", n, d, gbf_rd_addr, d);
                    end
                end
                if (d > 0) begin
                    total++;
                    if ({w_en, w_addr} !== {1'b1, 5'(d - 1)}) begin
                        bad++;
                        $display("FAIL acc_write n=%0d d=%0d got wen=%b wa=%0d exp 1 %0d",
                                 n, d, w_en, w_addr, d - 1);
                    end
                    total++;
                    if (out_data !== exp_out) begin
                        bad++;
                        $display("FAIL acc_data n=%0d d=%0d got=%h exp=%h", n, d, out_data, exp_out);
                    end
                end
                tick;
            end
            if (n == 0) start = 1'b1;
            @(negedge clk);
            total++;
            if (w_num !== 1'(n)) begin
                bad++;
                $display("FAIL acc_wnum n=%0d got=%b exp=%0d", n, w_num, n);
            end
            if (n == 0) begin
                tick;
                start = 1'b0;
            end
        end
        cfg_acc_en  = 1'b0;
        gbf_rd_data = '0;
        $display("test_accumulate done");
    endtask

    task automatic test_finish_mid_drain;
        apply_reset;
        cfg_rel_num = 8'd2; cfg_irrel_num = 8'd1; cfg_acc_en = 1'b0;
        load_pattern;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int d = 0; d <= SLICES; d++) begin
            conv_finish = (d == 3);
            @(negedge clk);
            total++;
            if ({busy, w_en, done, halted} !== {1'b1, (d != 0), (d == SLICES), 1'b0}) begin
                bad++;
                $display("FAIL fin_drain d=%0d got=%b exp=%b", d, {busy, w_en, done, halted},
                         {1'b1, (d != 0), (d == SLICES), 1'b0});
            end
            tick;
        end
        conv_finish = 1'b0;
        @(negedge clk);
        total++;
        if ({halted, busy, w_en, start_err, psum_rf_addr} !== {4'b1000, 2'd1}) begin
            bad++;
            $display("FAIL fin_halt got h=%b b=%b we=%b se=%b rf=%0d exp 1 0 0 0 1",
                     halted, busy, w_en, start_err, psum_rf_addr);
        end
        tick;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        @(negedge clk);
        total++;
        if ({halted, busy, w_en, gbf_rd_en, start_err} !== 5'b10001) begin
            bad++;
            $display("FAIL fin_start_ignored got=%b exp=10001", {halted, busy, w_en, gbf_rd_en, start_err});
        end
        $display("test_finish_mid_drain done");
    endtask

    task automatic test_reset_mid_drain;
        apply_reset;
        cfg_irrel_num = 8'd1; cfg_acc_en = 1'b0;
        load_pattern;
        // First drain flips w_num; second leaves rel_cnt at 1 (base 8).
        cfg_rel_num = 8'd1;
        start = 1'b1; tick; start = 1'b0;
        repeat (SLICES + 1) tick;
        cfg_rel_num = 8'd2;
        start = 1'b1; tick; start = 1'b0;
        repeat (SLICES + 1) tick;
        @(negedge clk);
        total++;
        if ({w_num, psum_rf_addr} !== {1'b1, 2'd2}) begin
            bad++;
            $display("FAIL rst_pre got wnum=%b rf=%0d exp 1 2", w_num, psum_rf_addr);
        end
        tick;
        start = 1'b1; tick; start = 1'b0;
        repeat (4) tick;
        @(negedge clk);
        total++;
        if ({w_en, busy, w_addr} !== {1'b1, 1'b1, 5'd11}) begin
            bad++;
            $display("FAIL rst_d4 got wen=%b busy=%b wa=%0d exp 1 1 11", w_en, busy, w_addr);
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({w_en, busy, done, halted, gbf_rd_en, w_num, start_err} !== 7'b0) begin
            bad++;
            $display("FAIL rst_async_flags got=%b exp=0000000",
                     {w_en, busy, done, halted, gbf_rd_en, w_num, start_err});
        end
        total++;
        if ({psum_rf_addr, w_addr} !== 7'b0 || out_data !== '0) begin
            bad++;
            $display("FAIL rst_async_values rf=%0d wa=%0d od_nonzero=%b exp all 0",
                     psum_rf_addr, w_addr, (out_data != '0));
        end
        tick;
        reset = 1'b0;
        start = 1'b1; tick; start = 1'b0;
        for (int d = 0; d <= SLICES; d++) begin
            @(negedge clk);
            if (d > 0) begin
                total++;
                if ({w_en, w_addr} !== {1'b1, 5'(d - 1)} || out_data !== pattern_slice(d - 1)) begin
                    bad++;
                    $display("FAIL rst_redrain d=%0d got wen=%b wa=%0d exp 1 %0d data_ok=%b",
                             d, w_en, w_addr, d - 1, (out_data === pattern_slice(d - 1)));
                end
            end
            tick;
        end
        $display("test_reset_mid_drain done");
    endtask

    task automatic test_start_finish_same;
        apply_reset;
        cfg_rel_num = 8'd2; cfg_irrel_num = 8'd1; cfg_acc_en = 1'b0;
        start = 1'b1; conv_finish = 1'b1;
        tick;
        start = 1'b0; conv_finish = 1'b0;
        @(negedge clk);
        total++;
        if ({halted, busy, w_en, done, start_err} !== 5'b10000) begin
            bad++;
            $display("FAIL both_halt got=%b exp=10000", {halted, busy, w_en, done, start_err});
        end
        for (int c = 0; c < SLICES + 2; c++) begin
            tick;
            @(negedge clk);
            total++;
            if ({halted, w_en, busy} !== 3'b100) begin
                bad++;
                $display("FAIL both_no_write c=%0d got=%b exp=100", c, {halted, w_en, busy});
            end
        end
        $display("test_start_finish_same done");
    endtask

    initial begin
        reset         = 1'b1;
        start         = 1'b0;
        conv_finish   = 1'b0;
        cfg_rel_num   = 8'd1;
        cfg_irrel_num = 8'd1;
        cfg_acc_en    = 1'b0;
        psum_out      = '0;
        gbf_rd_data   = '0;
        test_reset;
        test_single_drain;
        test_back_to_back;
        test_accumulate;
        test_finish_mid_drain;
        test_reset_mid_drain;
        test_start_finish_same;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
